// File: rtl/ascon_pkg.sv
// Shared constants for the ASCON bit-sliced S-box blocks: lane width,
// forward and inverse 5-bit tables (x0 is the column MSB) and FSM states.
package ascon_pkg;

  localparam int LANE_W = 64;

  localparam logic [4:0] ASCON_SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [4:0] ASCON_INV_SBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/ascon_inv_sbox_slice.sv
// Combinational inverse S-box over WIDTH 5-bit columns, one table lookup each.
module ascon_inv_sbox_slice
  import ascon_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0][4:0] col_in,
  output logic [WIDTH-1:0][4:0] col_out
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_col
    assign col_out[g] = ASCON_INV_SBOX[col_in[g]];
  end

endmodule

// File: rtl/ascon_inv_sbox_serial.sv
// Serial bit-sliced inverse ASCON S-box layer: WIDTH columns per cycle, valid/ready in and out.
// Define ASCON_INV_SBOX_CHECK_EN to add err_o, a forward-S-box self-check of every produced column.
module ascon_inv_sbox_serial
  import ascon_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int LANE_W = ascon_pkg::LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [LANE_W-1:0] x0_i,
  input  logic [LANE_W-1:0] x1_i,
  input  logic [LANE_W-1:0] x2_i,
  input  logic [LANE_W-1:0] x3_i,
  input  logic [LANE_W-1:0] x4_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LANE_W-1:0] x0_o,
  output logic [LANE_W-1:0] x1_o,
  output logic [LANE_W-1:0] x2_o,
  output logic [LANE_W-1:0] x3_o,
  output logic [LANE_W-1:0] x4_o
`ifdef ASCON_INV_SBOX_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int STEPS = LANE_W / WIDTH;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(WIDTH == 1 || WIDTH == 2 || WIDTH == 4 || WIDTH == 8) || (LANE_W % WIDTH) != 0) begin : g_bad_width
    $error("ascon_inv_sbox_serial: WIDTH must be 1/2/4/8 and divide LANE_W");
  end

  state_e                   state, state_nxt;
  logic [4:0][LANE_W-1:0]   lane;   // lane[k] holds xk
  logic [CW-1:0]            cnt;
  logic [WIDTH-1:0][4:0]    col_in, col_out;
  logic [4:0][WIDTH-1:0]    res;
  logic                     accept, last;

  // Gather the WIDTH LSB columns (x0 is the MSB) and scatter results back per lane.
  always_comb begin
    col_in = '0;
    res    = '0;
    for (int g = 0; g < WIDTH; g++) begin
      for (int k = 0; k < 5; k++) begin
        col_in[g][4-k] = lane[k][g];
        res[k][g]      = col_out[g][4-k];
      end
    end
  end

  ascon_inv_sbox_slice #(.WIDTH(WIDTH)) u_slice (
    .col_in  (col_in),
    .col_out (col_out)
  );

  assign last   = (cnt == CW'(STEPS - 1));
  assign accept = s_ready && s_valid;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Results enter at the MSB end, so after STEPS shifts every bit is home again.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      cnt  <= '0;
    end else if (accept) begin
      lane <= {x4_i, x3_i, x2_i, x1_i, x0_i};
      cnt  <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < 5; k++)
        lane[k] <= {res[k], lane[k][LANE_W-1:WIDTH]};
      cnt <= cnt + 1'b1;
    end
  end

  assign x0_o = lane[0];
  assign x1_o = lane[1];
  assign x2_o = lane[2];
  assign x3_o = lane[3];
  assign x4_o = lane[4];

`ifdef ASCON_INV_SBOX_CHECK_EN
  logic mism;

  always_comb begin
    mism = 1'b0;
    for (int g = 0; g < WIDTH; g++)
      if (ASCON_SBOX[col_out[g]] != col_in[g]) mism = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                         err_o <= 1'b0;
    else if (accept)                 err_o <= 1'b0;
    else if (state == RUN && mism)   err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ascon_inv_sbox_serial.sv
// Scoreboard bench for ascon_inv_sbox_serial at WIDTH=1: directed columns, forward-model round trip,
// backpressure and mid-run reset.
module tb_ascon_inv_sbox_serial;
  import ascon_pkg::*;

  typedef logic [4:0][63:0] lanes_t;
  typedef struct {
    lanes_t l;
    int     acc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst, s_valid, s_ready, m_valid, m_ready;
  lanes_t x_i;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
  lanes_t xo;
`ifdef ASCON_INV_SBOX_CHECK_EN
  logic err_o;
`endif

  assign xo = {x4_o, x3_o, x2_o, x1_o, x0_o};

  ascon_inv_sbox_serial #(.WIDTH(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .x0_i    (x_i[0]),
    .x1_i    (x_i[1]),
    .x2_i    (x_i[2]),
    .x3_i    (x_i[3]),
    .x4_i    (x_i[4]),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .x0_o    (x0_o),
    .x1_o    (x1_o),
    .x2_o    (x2_o),
    .x3_o    (x3_o),
    .x4_o    (x4_o)
`ifdef ASCON_INV_SBOX_CHECK_EN
    ,
    .err_o   (err_o)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   rel_cyc = -100;
  int   n_pass = 0;
  int   n_total = 0;
  bit   mv_prev = 1'b0;
  exp_t q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
  endtask

  function automatic lanes_t fwd(input lanes_t x);
    lanes_t     r;
    logic [4:0] c, y;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      c = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
      y = ASCON_SBOX[c];
      for (int k = 0; k < 5; k++) r[k][j] = y[4-k];
    end
    return r;
  endfunction

  function automatic lanes_t rnd();
    lanes_t r;
    for (int k = 0; k < 5; k++) r[k] = {$urandom(), $urandom()};
    return r;
  endfunction

  // Present din until accepted; queue expectation on the accepting cycle.
  task automatic send(input lanes_t din, input lanes_t req, input bit chk_rel);
    bit done = 1'b0;
    x_i     = din;
    s_valid = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (s_ready) begin
        q.push_back('{req, cyc});
        if (chk_rel) chk("accept_after_release", 64'(cyc), 64'(rel_cyc + 1));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    x_i     = ~din;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && q.size() != 0; n++) @(posedge clk);
    #1;
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: compares every presented output cycle against the scoreboard head.
  always @(negedge clk) begin
    if (rst) mv_prev <= 1'b0;
    else begin
      if (m_valid) begin
        if (q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
        else begin
          if (!mv_prev) chk("latency", 64'(cyc - q[0].acc), 64'd65);
          for (int k = 0; k < 5; k++) chk($sformatf("lane_x%0d", k), xo[k], q[0].l[k]);
          chk("s_ready_in_done", 64'(s_ready), 64'd0);
`ifdef ASCON_INV_SBOX_CHECK_EN
          chk("err_o", 64'(err_o), 64'd0);
`endif
          if (m_ready) begin
            rel_cyc = cyc;
            void'(q.pop_front());
          end
        end
      end
      mv_prev <= m_valid;
    end
  end

  lanes_t d, e, xr;

  initial begin
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; x_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    for (int k = 0; k < 5; k++) chk($sformatf("rst_x%0d", k), xo[k], 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Column 0x00 -> 0x14: x0 and x2 set.
    e = '0; e[0] = '1; e[2] = '1;
    send('0, e, 1'b0);
    // Column 0x04 -> 0x00.
    d = '0; d[2] = '1;
    send(d, '0, 1'b0);
    // Column 0x1F -> 0x02: x3 set.
    d = '1; e = '0; e[3] = '1;
    send(d, e, 1'b0);
    // Round trip through the forward model.
    for (int t = 0; t < 2; t++) begin
      xr = rnd();
      send(fwd(xr), xr, 1'b0);
    end
    drain();

    // Backpressure: hold DONE for 10 cycles with the next state already offered.
    xr = rnd();
    send(fwd(xr), xr, 1'b0);
    m_ready = 1'b0;
    for (int n = 0; n < 200 && !m_valid; n++) @(negedge clk);
    if (!m_valid) chk("bp_wait_timeout", 64'd0, 64'd1);
    d = rnd();
    fork
      send(fwd(d), d, 1'b1);
      begin
        repeat (10) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-run at cnt == 30; partial work is discarded.
    xr = rnd();
    send(fwd(xr), xr, 1'b0);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_s_ready", 64'(s_ready), 64'd1);
    chk("abort_m_valid", 64'(m_valid), 64'd0);
    for (int k = 0; k < 5; k++) chk($sformatf("abort_x%0d", k), xo[k], 64'd0);
    xr = rnd();
    send(fwd(xr), xr, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
